hs_rr_arb: RTL and testbench
============================

Name: hs_rr_arb

Overview:
- Round-robin arbiter that shares one valid/ready handshake channel among NUM_REQ requesters.
- Sits in front of the existing handshake buffers and merges several producers into one buffered stream.
- Each transfer is tagged with the index of its source.
- Contains one registered output stage: 1-cycle latency, full throughput (one transfer per cycle when ready_out is held high).

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
DATA_WD, 4, payload width per requester.
IDX_WD, $clog2(NUM_REQ), width of the source-index tag; derived, must not be overridden.

Ports:
clk  input  1  clock, all logic on rising edge.
rstn  input  1  asynchronous active-low reset.
valid_in  input  NUM_REQ  per-requester valid; bit i belongs to requester i.
data_in  input  NUM_REQ*DATA_WD  packed payloads; requester i occupies bits [i*DATA_WD +: DATA_WD].
ready_in  output  NUM_REQ  per-requester ready; at most one bit high in any cycle.
valid_out  output  1  registered output valid.
data_out  output  DATA_WD  registered output payload.
id_out  output  IDX_WD  registered index of the requester that supplied data_out.
ready_out  input  1  downstream ready.

Behaviour:
- Reset (rstn low, asynchronous): valid_out=0, data_out=0, id_out=0, rr_ptr=0, locked=0, lock_idx=0. ready_in is all-zero while valid_out=0 and no requester is asserting valid.
- Handshake definitions:
  - fire_in[i] = valid_in[i] && ready_in[i].
  - fire_out = valid_out && ready_out.
  - can_load = !valid_out || ready_out.
- Grant selection (combinational):
  - If locked=1: grant = lock_idx.
  - Else: grant = the first i with valid_in[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - No valid_in asserted: no grant.
- ready_in[grant] = can_load; all other ready_in bits = 0. ready_in never depends combinationally on valid_in of the requester being granted beyond grant selection.
- Lock (grant stability):
  - If a grant exists and can_load=0: locked<=1, lock_idx<=grant. The grant stays on that requester until it fires.
  - On fire_in of the locked requester: locked<=0.
  - A requester keeps valid_in high with stable data_in until it fires; the arbiter never retracts a grant to a waiting requester.
- Pointer: on any fire_in from requester g, rr_ptr <= (g+1) mod NUM_REQ. Otherwise rr_ptr holds. When g = NUM_REQ-1, rr_ptr wraps to 0.
- Output register:
  - On fire_in from g: valid_out<=1, data_out<=data_in[g], id_out<=g. This also covers a simultaneous fire_out (back-to-back transfer, no bubble).
  - Else if fire_out: valid_out<=0; data_out and id_out hold their values.
  - Else: all hold.
- Latency: data accepted at edge N appears on data_out/id_out after edge N; earliest downstream acceptance is edge N+1.
- Stall: valid_out=1 and ready_out=0 → all ready_in=0; output holds stable.
- Fairness: with all NUM_REQ requesters continuously valid and ready_out=1, grants rotate 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 transfers.
- A single active requester with ready_out=1 gets one transfer per cycle.
- Reset mid-operation: all state clears immediately, any in-flight output word is dropped, rr_ptr returns to 0.

Test Plan:
- Reset, then all four valid_in=1 with data_in[i]=i+8 and ready_out=1 held → id_out sequence 0,1,2,3,0,...; data_out 8,9,10,11; valid_out high every cycle from the second cycle after the first grant.
- Only requester 2 valid, ready_out=1 → ready_in=4'b0100 every cycle; one transfer per cycle; id_out=2.
- valid_in=4'b1010 with rr_ptr=0 and ready_out=0 after the first transfer → requester 1 is granted and locked. Raise valid_in[0]: grant stays on 1 until ready_out=1 and 1 fires; the next grant goes to 3, not 0.
- ready_out held 0 for 5 cycles with valid_out=1 → data_out/id_out stable; all ready_in=0; no fire_in. Release ready_out → output advances on the next edge.
- rr_ptr=3, requesters 3 and 0 valid → 3 is granted first, rr_ptr wraps to 0, then 0 is granted.
- Assert rstn low while valid_out=1 and locked=1 → valid_out=0, id_out=0, locked=0 immediately. After release, arbitration restarts from requester 0.
- Random valid_in/ready_out for 5000 cycles with per-requester incrementing counters as data → per-id output order is strictly increasing; no word is lost or duplicated; no ready_in bit is high for more than one requester at a time.

Source files
------------

// File: rtl/hs_rr_arb.sv
// Round-robin arbiter merging NUM_REQ valid/ready producers into one registered,
// index-tagged output stream with one cycle of latency and full throughput.
module hs_rr_arb #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_WD = 4,
  localparam int IDX_WD  = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         valid_in,
  input  logic [NUM_REQ*DATA_WD-1:0] data_in,
  output logic [NUM_REQ-1:0]         ready_in,
  output logic                       valid_out,
  output logic [DATA_WD-1:0]         data_out,
  output logic [IDX_WD-1:0]          id_out,
  input  logic                       ready_out
);

  logic                valid_q, valid_d;
  logic [DATA_WD-1:0]  data_q, data_d;
  logic [IDX_WD-1:0]   id_q, id_d;
  logic [IDX_WD-1:0]   rr_ptr_q, rr_ptr_d;
  logic                locked_q, locked_d;
  logic [IDX_WD-1:0]   lock_idx_q, lock_idx_d;

  logic                can_load;
  logic                gnt_vld;
  logic [IDX_WD-1:0]   gnt_idx;
  logic [IDX_WD-1:0]   cand;
  logic                fire_in;
  logic [DATA_WD-1:0]  din [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign din[i] = data_in[i*DATA_WD +: DATA_WD];
  end

  assign can_load = !valid_q || ready_out;

  // Descending scan so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (locked_q) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx_q;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = IDX_WD'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (valid_in[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    ready_in = '0;
    if (gnt_vld) ready_in[gnt_idx] = can_load;
  end

  assign fire_in = gnt_vld && valid_in[gnt_idx] && can_load;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    id_d       = id_q;
    rr_ptr_d   = rr_ptr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;

    if (fire_in) begin
      valid_d  = 1'b1;
      data_d   = din[gnt_idx];
      id_d     = gnt_idx;
      rr_ptr_d = (gnt_idx == IDX_WD'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_WD'(1);
    end else if (valid_q && ready_out) begin
      valid_d = 1'b0;
    end

    // A grant offered while the output is full is pinned until that requester fires.
    if (gnt_vld && !can_load) begin
      locked_d   = 1'b1;
      lock_idx_d = gnt_idx;
    end else if (fire_in && locked_q) begin
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      id_q       <= id_d;
      rr_ptr_q   <= rr_ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign id_out    = id_q;

endmodule

// File: tb/tb_hs_rr_arb.sv
// Bench for hs_rr_arb: directed scenarios plus a randomized run scored against a
// transaction-level model of the round-robin arbiter and its one-word output stage.
module tb_hs_rr_arb;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      valid_in;
  logic [N*DW-1:0]   data_in;
  logic [N-1:0]      ready_in;
  logic              valid_out;
  logic [DW-1:0]     data_out;
  logic [IW-1:0]     id_out;
  logic              ready_out;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  hs_rr_arb #(.NUM_REQ(N), .DATA_WD(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .id_out    (id_out),
    .ready_out (ready_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input int v);
    data_in[i*DW +: DW] = DW'(v);
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    valid_in  = '0;
    data_in   = '0;
    ready_out = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    valid_in  = '0;
    data_in   = '0;
    ready_out = 1'b0;
    #3;
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    vecs++; if (data_out !== '0) begin errs++; $display("FAIL reset_data got %h exp 0", data_out); end
    vecs++; if (id_out !== '0) begin errs++; $display("FAIL reset_id got %0d exp 0", id_out); end
    vecs++; if (ready_in !== '0) begin errs++; $display("FAIL reset_ready got %b exp 0000", ready_in); end
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_rotation();
    valid_in  = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, i + 8);
    ready_out = 1'b1;
    #1;
    vecs++; if (ready_in !== 4'b0001) begin errs++; $display("FAIL rot_first_ready got %b exp 0001", ready_in); end
    for (int k = 0; k < 8; k++) begin
      step();
      vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL rot_valid[%0d] got %b exp 1", k, valid_out); end
      vecs++; if (id_out !== IW'(k % N)) begin errs++; $display("FAIL rot_id[%0d] got %0d exp %0d", k, id_out, k % N); end
      vecs++; if (data_out !== DW'(k % N + 8)) begin errs++; $display("FAIL rot_data[%0d] got %0d exp %0d", k, data_out, k % N + 8); end
      vecs++; if (ready_in !== N'(1 << ((k + 1) % N))) begin
        errs++; $display("FAIL rot_ready[%0d] got %b exp %b", k, ready_in, N'(1 << ((k + 1) % N)));
      end
    end
    valid_in = '0;
    step();
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL rot_drain got %b exp 0", valid_out); end
  endtask

  task automatic test_single();
    valid_in  = 4'b0100;
    ready_out = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_data(2, c + 3);
      #1;
      vecs++; if (ready_in !== 4'b0100) begin errs++; $display("FAIL single_ready[%0d] got %b exp 0100", c, ready_in); end
      step();
      vecs++; if (valid_out !== 1'b1 || id_out !== IW'(2) || data_out !== DW'(c + 3)) begin
        errs++; $display("FAIL single_out[%0d] got v=%b id=%0d d=%0d exp v=1 id=2 d=%0d", c, valid_out, id_out, data_out, c + 3);
      end
    end
    valid_in = '0;
    step();
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL single_drain got %b exp 0", valid_out); end
  endtask

  task automatic test_wrap();
    valid_in = 4'b1001;
    set_data(0, 5);
    set_data(3, 6);
    #1;
    vecs++; if (ready_in !== 4'b1000) begin errs++; $display("FAIL wrap_ready3 got %b exp 1000", ready_in); end
    step();
    vecs++; if (id_out !== IW'(3) || data_out !== DW'(6)) begin errs++; $display("FAIL wrap_out3 got id=%0d d=%0d exp id=3 d=6", id_out, data_out); end
    valid_in = 4'b0001;
    #1;
    vecs++; if (ready_in !== 4'b0001) begin errs++; $display("FAIL wrap_ready0 got %b exp 0001", ready_in); end
    step();
    vecs++; if (id_out !== IW'(0) || data_out !== DW'(5)) begin errs++; $display("FAIL wrap_out0 got id=%0d d=%0d exp id=0 d=5", id_out, data_out); end
    valid_in = '0;
    step();
  endtask

  task automatic test_lock();
    do_reset();
    ready_out = 1'b0;
    valid_in  = 4'b1000;
    set_data(3, 4);
    #1;
    vecs++; if (ready_in !== 4'b1000) begin errs++; $display("FAIL lock_first_ready got %b exp 1000", ready_in); end
    step();
    valid_in = 4'b1010;
    set_data(1, 7);
    set_data(3, 9);
    #1;
    vecs++; if (ready_in !== 4'b0000) begin errs++; $display("FAIL lock_stall_ready got %b exp 0000", ready_in); end
    step();
    valid_in = 4'b1011;
    set_data(0, 2);
    #1;
    vecs++; if (ready_in !== 4'b0000) begin errs++; $display("FAIL lock_hold_ready got %b exp 0000", ready_in); end
    step();
    vecs++; if (valid_out !== 1'b1 || id_out !== IW'(3) || data_out !== DW'(4)) begin
      errs++; $display("FAIL lock_hold_out got v=%b id=%0d d=%0d exp v=1 id=3 d=4", valid_out, id_out, data_out);
    end
    ready_out = 1'b1;
    #1;
    vecs++; if (ready_in !== 4'b0010) begin errs++; $display("FAIL lock_grant1 got %b exp 0010", ready_in); end
    step();
    vecs++; if (id_out !== IW'(1) || data_out !== DW'(7)) begin errs++; $display("FAIL lock_out1 got id=%0d d=%0d exp id=1 d=7", id_out, data_out); end
    valid_in = 4'b1001;
    #1;
    vecs++; if (ready_in !== 4'b1000) begin errs++; $display("FAIL lock_next3 got %b exp 1000", ready_in); end
    step();
    vecs++; if (id_out !== IW'(3) || data_out !== DW'(9)) begin errs++; $display("FAIL lock_out3 got id=%0d d=%0d exp id=3 d=9", id_out, data_out); end
    valid_in = 4'b0001;
    step();
    vecs++; if (id_out !== IW'(0) || data_out !== DW'(2)) begin errs++; $display("FAIL lock_out0 got id=%0d d=%0d exp id=0 d=2", id_out, data_out); end
    valid_in = '0;
    step();
  endtask

  task automatic test_stall();
    valid_in = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, i + 8);
    ready_out = 1'b1;
    step();
    vecs++; if (id_out !== IW'(1) || data_out !== DW'(9)) begin errs++; $display("FAIL stall_load got id=%0d d=%0d exp id=1 d=9", id_out, data_out); end
    ready_out = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      vecs++; if (valid_out !== 1'b1 || id_out !== IW'(1) || data_out !== DW'(9) || ready_in !== 4'b0000) begin
        errs++; $display("FAIL stall_hold[%0d] got v=%b id=%0d d=%0d rdy=%b exp v=1 id=1 d=9 rdy=0000", k, valid_out, id_out, data_out, ready_in);
      end
    end
    ready_out = 1'b1;
    #1;
    vecs++; if (ready_in !== 4'b0100) begin errs++; $display("FAIL stall_release_ready got %b exp 0100", ready_in); end
    step();
    vecs++; if (id_out !== IW'(2) || data_out !== DW'(10)) begin errs++; $display("FAIL stall_advance got id=%0d d=%0d exp id=2 d=10", id_out, data_out); end
    valid_in = '0;
    step();
  endtask

  task automatic test_reset_mid();
    valid_in = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, i + 8);
    ready_out = 1'b1;
    step();
    step();
    ready_out = 1'b0;
    step();
    vecs++; if (valid_out !== 1'b1 || id_out !== IW'(0)) begin errs++; $display("FAIL mid_pre got v=%b id=%0d exp v=1 id=0", valid_out, id_out); end
    rstn = 1'b0;
    #1;
    vecs++; if (valid_out !== 1'b0 || id_out !== IW'(0) || data_out !== DW'(0)) begin
      errs++; $display("FAIL mid_reset_out got v=%b id=%0d d=%0d exp v=0 id=0 d=0", valid_out, id_out, data_out);
    end
    vecs++; if (ready_in !== 4'b0001) begin errs++; $display("FAIL mid_reset_ready got %b exp 0001", ready_in); end
    step();
    rstn      = 1'b1;
    ready_out = 1'b1;
    step();
    vecs++; if (valid_out !== 1'b1 || id_out !== IW'(0) || data_out !== DW'(8)) begin
      errs++; $display("FAIL mid_restart got v=%b id=%0d d=%0d exp v=1 id=0 d=8", valid_out, id_out, data_out);
    end
    valid_in = '0;
    step();
  endtask

  task automatic test_random();
    bit            vld [N];
    int            cnt [N];
    int            seen [N];
    bit            m_full;
    int            m_id, m_data, m_last, m_wait;
    int            g;
    bit            can, fire;
    logic [N-1:0]  exp_rdy;
    do_reset();
    m_full = 1'b0; m_id = 0; m_data = 0; m_last = N - 1; m_wait = -1;
    for (int i = 0; i < N; i++) begin vld[i] = 1'b0; cnt[i] = 0; seen[i] = -1; end
    for (int cyc = 0; cyc < 5000; cyc++) begin
      ready_out = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!vld[i]) vld[i] = 1'($urandom_range(0, 1));
        valid_in[i] = vld[i];
        set_data(i, cnt[i]);
      end
      #1;
      can = !m_full || ready_out;
      g = -1;
      if (m_wait >= 0) g = m_wait;
      else for (int k = 0; k < N; k++) if (g < 0 && vld[(m_last + 1 + k) % N]) g = (m_last + 1 + k) % N;
      exp_rdy = (g >= 0 && can) ? N'(1) << g : '0;
      vecs++; if (ready_in !== exp_rdy) begin errs++; $display("FAIL rand_ready[%0d] got %b exp %b", cyc, ready_in, exp_rdy); end
      vecs++; if ($countones(ready_in) > 1) begin errs++; $display("FAIL rand_onehot[%0d] got %b exp at most one bit", cyc, ready_in); end
      fire = (g >= 0) && can && vld[g];
      if (fire) begin
        m_full = 1'b1; m_id = g; m_data = cnt[g]; m_last = g; m_wait = -1;
        cnt[g] = (cnt[g] + 1) % (1 << DW);
        vld[g] = 1'($urandom_range(0, 1));
      end else begin
        if (m_full && ready_out) m_full = 1'b0;
        if (g >= 0 && !can) m_wait = g;
      end
      step();
      vecs++; if (valid_out !== m_full) begin errs++; $display("FAIL rand_valid[%0d] got %b exp %b", cyc, valid_out, m_full); end
      if (m_full) begin
        vecs++; if (id_out !== IW'(m_id) || data_out !== DW'(m_data)) begin
          errs++; $display("FAIL rand_word[%0d] got id=%0d d=%0d exp id=%0d d=%0d", cyc, id_out, data_out, m_id, m_data);
        end
      end
      if (fire) begin
        vecs++; if (data_out !== DW'((seen[g] + 1) % (1 << DW))) begin
          errs++; $display("FAIL rand_order[%0d] id=%0d got %0d exp %0d", cyc, g, data_out, (seen[g] + 1) % (1 << DW));
        end
        seen[g] = int'(data_out);
      end
    end
    ready_out = 1'b0;
    valid_in  = '0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_wrap();
    test_lock();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
